// File: rtl/time_display_mux.sv
// time_display_mux: drives a 4-digit multiplexed 7-segment HH:MM display from binary time.
// Latency: all outputs are registered and reflect the previous cycle's digit/snapshot/phase.
// Flow control: none; ena=0 blanks the outputs and freezes every counter and the snapshot.
module time_display_mux #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_HALF = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic       alarm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] digit_en
);

  localparam int SW = (SCAN_DIV   > 2) ? $clog2(SCAN_DIV)   : 1;
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [6:0]    SEG_DASH   = 7'b1000000;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          load_pending;
  logic [4:0]    shadow_h;
  logic [5:0]    shadow_m;

  logic          scan_wrap;
  logic          blink_wrap;
  logic          snap;
  logic [4:0]    disp_h;
  logic [5:0]    disp_m;
  logic [5:0]    pair_val;
  logic          pair_dash;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [6:0]    digit_seg;

  // Decimal digit to segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    seg_font = 7'b0111111;
      4'd1:    seg_font = 7'b0000110;
      4'd2:    seg_font = 7'b1011011;
      4'd3:    seg_font = 7'b1001111;
      4'd4:    seg_font = 7'b1100110;
      4'd5:    seg_font = 7'b1101101;
      4'd6:    seg_font = 7'b1111101;
      4'd7:    seg_font = 7'b0000111;
      4'd8:    seg_font = 7'b1111111;
      4'd9:    seg_font = 7'b1101111;
      default: seg_font = 7'b0000000;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  // Snapshot at the last cycle of the frame, or immediately after reset so the
  // very first frame already shows live time rather than the reset zeros.
  assign snap       = load_pending || ((idx == 2'd3) && scan_wrap);

  // Select and encode the digit addressed by idx; the first post-reset cycle
  // bypasses the still-empty shadow so it matches the value being captured.
  always_comb begin
    disp_h = load_pending ? hours   : shadow_h;
    disp_m = load_pending ? minutes : shadow_m;
    if (idx[1]) begin
      pair_val  = disp_m;
      pair_dash = (disp_m > 6'd59);
    end else begin
      pair_val  = {1'b0, disp_h};
      pair_dash = (disp_h > 5'd23);
    end
    tens      = 4'(pair_val / 6'd10);
    ones      = 4'(pair_val % 6'd10);
    digit_seg = pair_dash ? SEG_DASH : seg_font(idx[0] ? ones : tens);
  end

  // Digit scan: each digit stays lit for SCAN_DIV enabled cycles, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (ena) begin
      if (scan_wrap) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  // Blink timebase: phase toggles every BLINK_HALF enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (ena) begin
      if (blink_wrap) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Frame snapshot so a scan frame never mixes two different times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_h     <= 5'd0;
      shadow_m     <= 6'd0;
      load_pending <= 1'b1;
    end else if (ena) begin
      if (snap) begin
        shadow_h <= hours;
        shadow_m <= minutes;
      end
      load_pending <= 1'b0;
    end
  end

  // Registered display outputs; alarm flash blanks segments but keeps scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= 7'd0;
      dp       <= 1'b0;
      digit_en <= 4'd0;
    end else if (!ena) begin
      seg      <= 7'd0;
      dp       <= 1'b0;
      digit_en <= 4'd0;
    end else begin
      seg      <= (alarm && !phase) ? 7'd0 : digit_seg;
      dp       <= (idx == 2'd1) && (phase || alarm);
      digit_en <= 4'b0001 << idx;
    end
  end

endmodule

// File: tb/tb_time_display_mux.sv
// tb_time_display_mux: checks time_display_mux against an arithmetic model every cycle.
// The model derives digit and blink phase from the count of enabled cycles since reset.
// Directed phases pin literal values; a random phase exercises ena, inputs and alarm.
module tb_time_display_mux;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 16;
  localparam int FRAME      = 4 * SCAN_DIV;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       alarm;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit_en;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  time_display_mux #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_HALF(BLINK_HALF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .hours   (hours),
    .minutes (minutes),
    .alarm   (alarm),
    .seg     (seg),
    .dp      (dp),
    .digit_en(digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] font(input int d);
    case (d)
      0: font = 7'b0111111;
      1: font = 7'b0000110;
      2: font = 7'b1011011;
      3: font = 7'b1001111;
      4: font = 7'b1100110;
      5: font = 7'b1101101;
      6: font = 7'b1111101;
      7: font = 7'b0000111;
      8: font = 7'b1111111;
      9: font = 7'b1101111;
      default: font = 7'b0000000;
    endcase
  endfunction

  // n = number of enabled cycles already completed before this edge.
  function automatic logic [11:0] model_out(input int n, input int h, input int m, input logic al);
    int idx;
    int v;
    logic ph;
    logic dash;
    logic [6:0] s;
    idx = (n / SCAN_DIV) % 4;
    ph  = ((n / BLINK_HALF) % 2) == 0;
    case (idx)
      0:       begin dash = (h > 23); v = h / 10; end
      1:       begin dash = (h > 23); v = h % 10; end
      2:       begin dash = (m > 59); v = m / 10; end
      default: begin dash = (m > 59); v = m % 10; end
    endcase
    s = dash ? 7'b1000000 : font(v);
    if (al && !ph) s = 7'b0000000;
    model_out = {s, (idx == 1) && (ph || al), 4'(1 << idx)};
  endfunction

  int         n_en;
  int         m_h;
  int         m_m;
  logic       m_pend;
  logic [11:0] exp_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_en    <= 0;
      m_h     <= 0;
      m_m     <= 0;
      m_pend  <= 1'b1;
      exp_out <= '0;
    end else if (!ena) begin
      exp_out <= '0;
    end else begin
      exp_out <= model_out(n_en, m_pend ? int'(hours) : m_h,
                           m_pend ? int'(minutes) : m_m, alarm);
      if (m_pend || (n_en % FRAME) == FRAME - 1) begin
        m_h <= int'(hours);
        m_m <= int'(minutes);
      end
      m_pend <= 1'b0;
      n_en   <= n_en + 1;
    end
  end

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({seg, dp, digit_en} !== exp_out) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got seg=%b dp=%b digit_en=%b, want seg=%b dp=%b digit_en=%b",
                 $time, seg, dp, digit_en, exp_out[11:5], exp_out[4], exp_out[3:0]);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input logic [11:0] want);
    checks++;
    if ({seg, dp, digit_en} !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got seg=%b dp=%b digit_en=%b, want seg=%b dp=%b digit_en=%b",
               name, $time, seg, dp, digit_en, want[11:5], want[4], want[3:0]);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; hours = 5'd12; minutes = 6'd34; alarm = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {7'b0000000, 1'b0, 4'b0000});
    chk_en = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1; ena = 1'b1;

    // Basic 12:34 scan
    tick(1); chk("d0_12:34", {7'b0000110, 1'b0, 4'b0001});
    tick(4); chk("d1_12:34", {7'b1011011, 1'b1, 4'b0010});
    tick(4); chk("d2_12:34", {7'b1001111, 1'b0, 4'b0100});
    tick(4); chk("d3_12:34", {7'b1100110, 1'b0, 4'b1000});

    // Mid-frame input change stays invisible until the next frame
    tick(8); chk("d1_frame2", {7'b1011011, 1'b0, 4'b0010});
    hours = 5'd23; minutes = 6'd59;
    tick(4); chk("d2_torn_guard", {7'b1001111, 1'b0, 4'b0100});
    tick(8); chk("d0_23:59", {7'b1011011, 1'b0, 4'b0001});
    tick(12); chk("d3_23:59", {7'b1101111, 1'b0, 4'b1000});

    // Out-of-range hours, valid minutes
    hours = 5'd25; minutes = 6'd7;
    tick(4); chk("dash_h0", {7'b1000000, 1'b0, 4'b0001});
    tick(8); chk("m_tens_07", {7'b0111111, 1'b0, 4'b0100});
    tick(4); chk("m_ones_07", {7'b0000111, 1'b0, 4'b1000});

    // Alarm flash: phase 0 blanks segments, dp forced on at digit 1
    hours = 5'd12; minutes = 6'd34; alarm = 1'b1;
    tick(1);  chk("alarm_blank_d3", {7'b0000000, 1'b0, 4'b1000});
    tick(23); chk("alarm_dp_d1", {7'b0000000, 1'b1, 4'b0010});
    alarm = 1'b0;

    // Enable dropped mid-digit for 10 cycles
    tick(6); ena = 1'b0;
    tick(1); chk("ena_off_blank", {7'b0000000, 1'b0, 4'b0000});
    tick(9); ena = 1'b1;
    tick(20);

    // Randomised traffic
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #2;
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) hours   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) alarm   = ~alarm;
    end

    // Asynchronous reset between edges, then fresh snapshot 05:00
    ena = 1'b1; alarm = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("async_reset", {7'b0000000, 1'b0, 4'b0000});
    hours = 5'd5; minutes = 6'd0;
    #2 rst_n = 1'b1;
    tick(1); chk("post_rst_d0", {7'b0111111, 1'b0, 4'b0001});
    tick(4); chk("post_rst_d1", {7'b1101101, 1'b1, 4'b0010});
    tick(4); chk("post_rst_d2", {7'b0111111, 1'b0, 4'b0100});
    tick(4); chk("post_rst_d3", {7'b0111111, 1'b0, 4'b1000});
    tick(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_display_mux.md
Name: time_display_mux

Overview:
Downstream consumer of the clock/alarm counter. Takes the binary hours/minutes/alarm outputs and drives a 4-digit, multiplexed, common-anode-agnostic 7-segment display (HH:MM). Contents are latched once per scan frame so a frame never shows a torn time. Provides a blinking colon and a full-display flash while the alarm is asserted.

Parameters:
SCAN_DIV, 1000, clk cycles each digit is lit (>=2)
BLINK_HALF, 500000, clk cycles per half-period of colon/alarm blink (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  display enable; 0 blanks outputs and freezes all counters
hours  input  5  binary hours from clock counter, valid 0..23
minutes  input  6  binary minutes from clock counter, valid 0..59
alarm  input  1  alarm active flag from clock counter
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
dp  output  1  decimal point / colon, active-high
digit_en  output  4  one-hot digit select, active-high; bit0 = leftmost digit

Behaviour:
- Reset is asynchronous on rst_n, active-low; clock is clk (rising edge).
- Reset values: seg=0, dp=0, digit_en=0, scan_cnt=0, idx=0, shadow_h=0, shadow_m=0, blink_cnt=0, phase=1 (on), load_pending=1.
- All outputs registered; outputs reflect idx/shadow/phase of the previous cycle (1-cycle latency).
- scan_cnt counts 0..SCAN_DIV-1 while ena=1; at SCAN_DIV-1 wraps to 0 and idx advances mod 4 (3->0).
- Digit map: idx0 = hours tens, idx1 = hours ones, idx2 = minutes tens, idx3 = minutes ones; digit_en = 1<<idx. No leading-zero blanking.
- Snapshot: shadow_h/shadow_m <= hours/minutes on the cycle where idx==3 and scan_cnt==SCAN_DIV-1 (same edge idx->0), or on the first ena=1 cycle while load_pending=1 (clears load_pending). Input changes mid-frame are invisible until the next frame.
- BCD: tens = shadow/10, ones = shadow%10. Encoding gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Out of range: shadow_h>23 -> idx0/idx1 show dash 1000000; shadow_m>59 -> idx2/idx3 show dash. Pairs are independent.
- Blink: blink_cnt counts 0..BLINK_HALF-1 while ena=1; at wrap, phase toggles.
- dp: 1 only when idx==1 and (phase==1 or alarm==1); 0 on all other digits.
- Alarm flash: while alarm==1 and phase==0, seg=0 on every digit; digit_en still scans. alarm==0: seg always shows digits.
- ena=0: next edge seg=0, dp=0, digit_en=0; scan_cnt, idx, blink_cnt, phase, shadow hold. On ena returning to 1, scanning resumes from the held idx/scan_cnt.
- rst_n low at any time, including mid-frame: immediate return to reset values; first frame after release loads a fresh snapshot.

Test Plan:
SCAN_DIV=4, BLINK_HALF=16 for all benches.
- Reset, release, ena=1, hours=12, minutes=34 -> after 1 cycle digit_en=0001 seg=0000110; then every 4 clk: 0010/1011011 dp=1, 0100/1001111, 1000/1100110; repeats.
- While digit_en=0010 in frame showing 12:34, change inputs to 23:59 -> rest of frame shows 2,3,4; next frame shows 2,3,5,9.
- hours=25, minutes=07 -> digits 0/1 seg=1000000, digits 2/3 seg=0111111/0000111.
- alarm=0, 12:34 -> dp on digit 1 toggles every 16 clk; alarm=1 -> dp held 1, seg=0 on all digits for 16 clk of each 32, digit_en keeps scanning.
- ena=0 mid digit 2 for 10 clk -> outputs 0 from next cycle; ena=1 -> digit 2 resumes with remaining scan_cnt, blink phase unchanged.
- Assert rst_n low mid-frame (async, between edges) -> outputs 0 immediately; release with hours=5, minutes=0 -> first frame shows 0,5,0,0.
